// File: rtl/game_master_ctrl_if.sv
// Game-control bus between the button/flag sources and the master sequencer.
// slave is the sequencer's view; master is the view of whoever drives the
// buttons and the snake/target flags.
interface game_master_ctrl_if;
  logic       BTN_START;
  logic       BTN_PAUSE;
  logic       DEATH;
  logic       TARGET_REACHED;
  logic [1:0] MSM_STATE;
  logic       PAUSED;
  logic       MOVE_TICK;
  logic [3:0] SCORE;
  logic       NEW_TARGET;

  modport slave (
    input  BTN_START, BTN_PAUSE, DEATH, TARGET_REACHED,
    output MSM_STATE, PAUSED, MOVE_TICK, SCORE, NEW_TARGET
  );

  modport master (
    output BTN_START, BTN_PAUSE, DEATH, TARGET_REACHED,
    input  MSM_STATE, PAUSED, MOVE_TICK, SCORE, NEW_TARGET
  );
endinterface

// File: rtl/game_master_ctrl.sv
// Snake game master sequencer: Idle/Play/Win/Lose state, pause flag,
// score counter, new-target request and the speed-scaled move tick.
module game_master_ctrl #(
  parameter int unsigned TICK_PERIOD = 10000000,
  parameter int unsigned SPEED_STEP  = 500000,
  parameter int unsigned TICK_MIN    = 2500000,
  parameter int unsigned WIN_SCORE   = 10
) (
  input  logic              CLK,
  input  logic              RESET_N,
  game_master_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_WIN  = 2'd2,
    S_LOSE = 2'd3
  } state_e;

  state_e      state_q;
  logic        paused_q;
  logic        tick_q;
  logic        newtgt_q;
  logic [3:0]  score_q;
  logic [23:0] cnt_q;
  logic        start_q, pause_q, tgt_q;

  logic        start_rise, pause_rise, tgt_rise;
  logic        lose_hit, score_hit, win_hit;
  logic [27:0] step_d, period_d;
  logic        wrap_d;
  logic [3:0]  score_inc_d;

  assign start_rise = bus.BTN_START & ~start_q;
  assign pause_rise = bus.BTN_PAUSE & ~pause_q;
  assign tgt_rise   = bus.TARGET_REACHED & ~tgt_q;

  // Game events in PLAY; death takes priority over a simultaneous target hit.
  assign score_inc_d = score_q + 4'd1;
  assign lose_hit    = ~paused_q & bus.DEATH;
  assign score_hit   = ~paused_q & tgt_rise & ~lose_hit;
  assign win_hit     = score_hit & (score_inc_d == 4'(WIN_SCORE));

  // Move period from the current score, clamped at TICK_MIN (also when the
  // subtraction would go negative).
  always_comb begin
    step_d = 28'(score_q) * 28'(SPEED_STEP);
    if (step_d > 28'(TICK_PERIOD) || (28'(TICK_PERIOD) - step_d) < 28'(TICK_MIN))
      period_d = 28'(TICK_MIN);
    else
      period_d = 28'(TICK_PERIOD) - step_d;
  end

  // ">=" rather than "==" so a period shortened below the current count
  // wraps on the next counting cycle instead of running to 2^24.
  assign wrap_d = (28'(cnt_q) + 28'd1) >= period_d;

  // Edge-detect copies, state machine and all registered outputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      paused_q <= 1'b0;
      tick_q   <= 1'b0;
      newtgt_q <= 1'b0;
      score_q  <= 4'd0;
      cnt_q    <= 24'd0;
      start_q  <= 1'b0;
      pause_q  <= 1'b0;
      tgt_q    <= 1'b0;
    end else begin
      start_q  <= bus.BTN_START;
      pause_q  <= bus.BTN_PAUSE;
      tgt_q    <= bus.TARGET_REACHED;
      tick_q   <= 1'b0;
      newtgt_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_rise) begin
            state_q  <= S_PLAY;
            score_q  <= 4'd0;
            paused_q <= 1'b0;
            cnt_q    <= 24'd0;
          end
        end
        S_PLAY: begin
          if (!paused_q)
            cnt_q <= wrap_d ? 24'd0 : cnt_q + 24'd1;
          // A tick is only issued if we stay in PLAY and unpaused, so it can
          // never be seen outside PLAY or alongside PAUSED=1.
          tick_q <= ~paused_q & wrap_d & ~lose_hit & ~win_hit & ~pause_rise;
          if (score_hit) begin
            score_q  <= score_inc_d;
            newtgt_q <= 1'b1;
          end
          // Leaving PLAY clears the pause flag even if pause rose on that edge.
          if (lose_hit) begin
            state_q  <= S_LOSE;
            paused_q <= 1'b0;
          end else if (win_hit) begin
            state_q  <= S_WIN;
            paused_q <= 1'b0;
          end else begin
            paused_q <= paused_q ^ pause_rise;
          end
        end
        default: begin
          if (start_rise)
            state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.MSM_STATE  = state_q;
  assign bus.PAUSED     = paused_q;
  assign bus.MOVE_TICK  = tick_q;
  assign bus.SCORE      = score_q;
  assign bus.NEW_TARGET = newtgt_q;

endmodule

// File: tb/tb_game_master_ctrl.sv
// Bench for game_master_ctrl: unit A (WIN_SCORE=3) for the game flow,
// unit B (WIN_SCORE=15) for the period clamp.
module tb_game_master_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic b_start = 1'b0, b_pause = 1'b0, b_death = 1'b0, b_tgt = 1'b0;
  logic sel = 1'b0;

  game_master_ctrl_if ifa ();
  game_master_ctrl_if ifb ();

  assign ifa.BTN_START      = ~sel & b_start;
  assign ifa.BTN_PAUSE      = ~sel & b_pause;
  assign ifa.DEATH          = ~sel & b_death;
  assign ifa.TARGET_REACHED = ~sel & b_tgt;
  assign ifb.BTN_START      = sel & b_start;
  assign ifb.BTN_PAUSE      = sel & b_pause;
  assign ifb.DEATH          = sel & b_death;
  assign ifb.TARGET_REACHED = sel & b_tgt;

  game_master_ctrl #(.TICK_PERIOD(10), .SPEED_STEP(2), .TICK_MIN(4), .WIN_SCORE(3))
    dut_a (.CLK(clk), .RESET_N(rst_n), .bus(ifa.slave));
  game_master_ctrl #(.TICK_PERIOD(10), .SPEED_STEP(2), .TICK_MIN(4), .WIN_SCORE(15))
    dut_b (.CLK(clk), .RESET_N(rst_n), .bus(ifb.slave));

  logic [1:0] o_st;
  logic       o_paused, o_tick, o_nt;
  logic [3:0] o_score;
  always_comb begin
    o_st     = sel ? ifb.MSM_STATE  : ifa.MSM_STATE;
    o_paused = sel ? ifb.PAUSED     : ifa.PAUSED;
    o_tick   = sel ? ifb.MOVE_TICK  : ifa.MOVE_TICK;
    o_nt     = sel ? ifb.NEW_TARGET : ifa.NEW_TARGET;
    o_score  = sel ? ifb.SCORE      : ifa.SCORE;
  end

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       start, pause, death, tgt;
    logic [1:0] st;
    logic       paused;
    logic [3:0] score;
    logic       nt;
  } vec_t;

  typedef struct {
    string      name;
    logic [8:0] exp;
  } sb_t;

  sb_t sb_q[$];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Counts cycles until MOVE_TICK is seen; n=0 when the budget runs out.
  task automatic wait_tick(input int max, output int n);
    int i;
    i = 0;
    n = 0;
    while (n == 0 && i < max) begin
      i++;
      cyc();
      if (o_tick === 1'b1) n = i;
    end
  endtask

  function automatic logic [8:0] pack_out();
    return {o_st, o_paused, o_score, o_nt, o_tick};
  endfunction

  vec_t vt[12];
  int   n, cnt;

  initial begin
    // start pause death tgt | st paused score nt  (tick always expected 0)
    vt[0]  = '{1, 0, 0, 0, 2'd0, 0, 4'd3, 0};
    vt[1]  = '{0, 0, 0, 0, 2'd0, 0, 4'd3, 0};
    vt[2]  = '{1, 0, 0, 0, 2'd1, 0, 4'd0, 0};
    vt[3]  = '{1, 0, 0, 0, 2'd1, 0, 4'd0, 0};
    vt[4]  = '{0, 1, 0, 1, 2'd1, 1, 4'd1, 1};
    vt[5]  = '{0, 0, 0, 0, 2'd1, 1, 4'd1, 0};
    vt[6]  = '{0, 0, 1, 0, 2'd1, 1, 4'd1, 0};
    vt[7]  = '{0, 1, 0, 0, 2'd1, 0, 4'd1, 0};
    vt[8]  = '{0, 0, 1, 1, 2'd3, 0, 4'd1, 0};
    vt[9]  = '{0, 0, 0, 0, 2'd3, 0, 4'd1, 0};
    vt[10] = '{0, 0, 0, 1, 2'd3, 0, 4'd1, 0};
    vt[11] = '{1, 0, 0, 0, 2'd0, 0, 4'd1, 0};

    // Reset values on both units
    repeat (3) cyc();
    chk("reset_a", 32'(pack_out()), 0);
    sel = 1'b1;
    #1;
    chk("reset_b", 32'(pack_out()), 0);
    sel = 1'b0;
    #1;
    rst_n = 1'b1;
    cyc();

    // Start and base tick period
    b_start = 1'b1; cyc(); b_start = 1'b0;
    chk("start_state", 32'(o_st), 1);
    chk("start_score", 32'(o_score), 0);
    wait_tick(30, n); chk("first_tick", n, 10);
    wait_tick(30, n); chk("second_tick", n, 10);

    // Score 1 with a held target level, then period 8
    b_tgt = 1'b1; cyc();
    chk("score1", 32'(o_score), 1);
    chk("score1_nt", 32'(o_nt), 1);
    cnt = 0;
    repeat (19) begin cyc(); if (o_nt) cnt++; end
    chk("held_tgt_no_nt", cnt, 0);
    b_tgt = 1'b0;
    wait_tick(30, n);
    wait_tick(30, n); chk("period_s1", n, 8);

    // Score 2, period 6
    b_tgt = 1'b1; cyc(); b_tgt = 1'b0;
    chk("score2", 32'(o_score), 2);
    wait_tick(30, n);
    wait_tick(30, n); chk("period_s2", n, 6);

    // Third target wins
    b_tgt = 1'b1; cyc(); b_tgt = 1'b0;
    chk("win_state", 32'(o_st), 2);
    chk("win_score", 32'(o_score), 3);
    chk("win_nt", 32'(o_nt), 1);
    wait_tick(30, n); chk("win_no_tick", n, 0);
    chk("win_score_held", 32'(o_score), 3);

    // Table: restart, pause/target, death/target, lose -> idle
    for (int r = 0; r < 12; r++) begin
      b_start = vt[r].start; b_pause = vt[r].pause;
      b_death = vt[r].death; b_tgt = vt[r].tgt;
      sb_q.push_back('{$sformatf("row%0d", r),
                       {vt[r].st, vt[r].paused, vt[r].score, vt[r].nt, 1'b0}});
      cyc();
      begin
        sb_t e;
        e = sb_q.pop_front();
        chk(e.name, 32'(pack_out()), 32'(e.exp));
      end
    end
    b_pause = 1'b0; b_death = 1'b0; b_tgt = 1'b0;

    // Held start never retriggers (would re-enter PLAY from IDLE)
    cnt = 0;
    repeat (49) begin cyc(); if (o_st != 2'd0) cnt++; end
    chk("held_start_once", cnt, 0);
    b_start = 1'b0; cyc();

    // Pause at counter 4; inputs ignored while paused
    b_start = 1'b1; cyc(); b_start = 1'b0;
    chk("restart_state", 32'(o_st), 1);
    repeat (4) cyc();
    b_pause = 1'b1; cyc(); b_pause = 1'b0;
    chk("paused_set", 32'(o_paused), 1);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      b_tgt = (i % 2 == 1);
      b_death = (i == 10);
      cyc();
      if (o_tick || o_nt) cnt++;
    end
    b_tgt = 1'b0; b_death = 1'b0; cyc();
    chk("paused_quiet", cnt, 0);
    chk("paused_state", 32'({o_st, o_score}), 32'({2'd1, 4'd0}));
    b_pause = 1'b1; cyc(); b_pause = 1'b0;
    chk("resumed", 32'(o_paused), 0);
    wait_tick(20, n); chk("resume_tick", n, 5);

    // Async reset between edges cuts an in-flight tick
    wait_tick(20, n); chk("pre_reset_tick", n, 10);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 32'(pack_out()), 0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Unit B: period clamp at TICK_MIN
    sel = 1'b1;
    b_start = 1'b1; cyc(); b_start = 1'b0;
    chk("b_start", 32'(o_st), 1);
    for (int k = 1; k <= 6; k++) begin
      int exp_p;
      exp_p = (10 - 2 * k < 4) ? 4 : 10 - 2 * k;
      b_tgt = 1'b1; cyc(); b_tgt = 1'b0; cyc();
      chk($sformatf("b_score%0d", k), 32'(o_score), 32'(k));
      wait_tick(30, n);
      wait_tick(30, n);
      chk($sformatf("b_period_s%0d", k), n, exp_p);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
